ifetch_unit: RTL

Instruction fetch stage sitting directly upstream of the L1 instruction cache. Maintains the fetch PC, issues 8-byte aligned fetch requests on the I-cache CPU port, and splits each 64-bit response into two 32-bit instructions. Instructions are buffered in a fetch queue that feeds decode with a valid/ready handshake. Redirects from branch resolution or exceptions flush the queue and restart fetch.

---
 rtl/ifetch_pkg.sv | 21 ++
 rtl/ifetch_fetch_queue.sv | 72 +++++++
 rtl/ifetch_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states and fetch-queue entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ifetch_pkg;

    localparam int INST_WIDTH  = 32;
    // Queue entries carry the widest supported PC; narrower ADDR_WIDTH values are zero-extended.
    localparam int FQ_PC_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FQ_PC_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0]  inst;
    } fq_entry_t;

endpackage

// File: rtl/ifetch_fetch_queue.sv
// Circular fetch queue: up to 2 pushes and 1 pop per cycle, synchronous flush, occupancy count.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: none internally; the producer reserves space before launching, and overflow is asserted.
// Ports: clk/rst (async active-high), flush, push0/din0, push1/din1 (push1 implies push0, lands after din0),
//        pop (ignored when empty), head (entry at read pointer), count (registered occupancy).
module fetch_queue
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push0,
    input  fq_entry_t              din0,
    input  logic                   push1,
    input  fq_entry_t              din1,
    input  logic                   pop,
    output fq_entry_t              head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    fq_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_pop;
    logic [PW:0]     n_push;
    logic [PW+1:0]   level_next;

    assign do_pop     = pop && (count != '0);
    assign n_push     = (PW+1)'(push0) + (PW+1)'(push1);
    assign level_next = (PW+2)'(count) + (PW+2)'(n_push) - (PW+2)'(do_pop);
    assign head       = mem[rd_ptr];

    // Storage needs no reset: entries are only observed when count says they are valid.
    always_ff @(posedge clk) begin
        if (push0) begin
            mem[wr_ptr] <= din0;
        end
        if (push1) begin
            mem[wr_ptr + PW'(1)] <= din1;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + n_push[PW-1:0];
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + n_push - (PW+1)'(do_pop);
        end
    end

    always @(posedge clk) begin
        if (!rst && !flush) begin
            assert (level_next <= (PW+2)'(DEPTH));
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: 8-byte aligned I-cache requests, split into two instructions, queued for decode.
// Latency: instructions appear on inst_valid the cycle after an I-cache completion; one fetch per cycle on hits.
// Backpressure: a fetch launches only with 2 free queue slots (registered count); decode stalls via inst_ready.
// Ports: clk, rst (async active-high), fetch_en, redirect_valid/redirect_pc,
//        ic_addr/ic_req/ic_ready/ic_hit/ic_rdata (I-cache CPU port),
//        inst_valid/inst_ready/inst_data/inst_pc (decode handshake), perf_fetches/perf_redirects (saturating).
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    FQ_DEPTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(64'h0000_0000_8000_0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] ic_addr,
    output logic                  ic_req,
    input  logic                  ic_ready,
    input  logic                  ic_hit,
    input  logic [DATA_WIDTH-1:0] ic_rdata,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [31:0]           perf_fetches,
    output logic [31:0]           perf_redirects
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    fetch_state_t          state, state_next;
    logic [ADDR_WIDTH-1:0] pc, pc_next, pc_aligned;
    logic [ADDR_WIDTH-1:0] disc_addr;
    logic [CW-1:0]         count;
    logic [CW:0]           n_push, level_after;
    logic                  completion, fetch_done;
    logic                  push0, push1, pop;
    fq_entry_t             din0, din1, head;
    logic [INST_WIDTH-1:0] word0, word1;

    assign pc_aligned = {pc[ADDR_WIDTH-1:3], 3'b000};
    assign ic_req     = (state != IDLE);
    // While discarding, pc already holds the redirect target; the cache must still see the old address.
    assign ic_addr    = (state == DISCARD) ? disc_addr : pc_aligned;
    assign completion = ic_req && ic_ready && ic_hit;

    // Only a live (non-discarded, non-redirected) completion pushes.
    assign fetch_done = completion && (state == REQ) && !redirect_valid;
    assign word0      = ic_rdata[INST_WIDTH-1:0];
    assign word1      = ic_rdata[2*INST_WIDTH-1:INST_WIDTH];
    // A fetch entered at the upper word yields a single instruction, routed through slot 0.
    assign push0      = fetch_done;
    assign push1      = fetch_done && !pc[2];
    assign din0       = '{pc: FQ_PC_WIDTH'(pc), inst: (pc[2] ? word1 : word0)};
    assign din1       = '{pc: FQ_PC_WIDTH'(pc_aligned + ADDR_WIDTH'(4)), inst: word1};

    assign inst_valid = (count != '0);
    assign pop        = inst_ready && inst_valid;
    assign inst_data  = inst_valid ? head.inst : '0;
    assign inst_pc    = inst_valid ? head.pc[ADDR_WIDTH-1:0] : '0;

    // Occupancy once this cycle's push and pop have landed; decides back-to-back issue.
    assign n_push      = (CW+1)'(push0) + (CW+1)'(push1);
    assign level_after = (CW+1)'(count) + n_push - (CW+1)'(pop);

    always_comb begin
        state_next = state;
        pc_next    = pc;
        unique case (state)
            IDLE: begin
                if (!redirect_valid && fetch_en && count <= CW'(FQ_DEPTH - 2)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    state_next = completion ? IDLE : DISCARD;
                end else if (completion) begin
                    pc_next    = pc_aligned + ADDR_WIDTH'(8);
                    state_next = (fetch_en && level_after <= (CW+1)'(FQ_DEPTH - 2)) ? REQ : IDLE;
                end
            end
            DISCARD: begin
                if (completion) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (redirect_valid) begin
            pc_next = redirect_pc & ~ADDR_WIDTH'(3);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            disc_addr      <= '0;
            perf_fetches   <= '0;
            perf_redirects <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == REQ && redirect_valid && !completion) begin
                disc_addr <= pc_aligned;
            end
            if (fetch_done && perf_fetches != 32'hFFFF_FFFF) begin
                perf_fetches <= perf_fetches + 32'd1;
            end
            if (redirect_valid && perf_redirects != 32'hFFFF_FFFF) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push0 (push0),
        .din0  (din0),
        .push1 (push1),
        .din1  (din1),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

endmodule
